// File: rtl/conv_block_scheduler_pkg.sv
// Shared constants and helpers for the convolution block scheduler.
package conv_block_scheduler_pkg;

  localparam int unsigned N_CONV_DEFAULT = 16;
  localparam int unsigned KERNEL_OVERLAP = 2;
  localparam int unsigned MIN_IMG_DIM    = 3;

  // Scheduler state encodings
  localparam int unsigned ST_IDLE  = 0;
  localparam int unsigned ST_LOAD  = 1;
  localparam int unsigned ST_PROC  = 2;
  localparam int unsigned ST_DRAIN = 3;
  localparam int unsigned ST_NEXT  = 4;

  // Ceiling log2, usable in constant expressions
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned res;
    res = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'd1 << i) < 64'(value)) res = i + 1;
    end
    return res;
  endfunction

endpackage

// File: rtl/conv_block_scheduler_edge_detect_rise.sv
// Registered rising-edge detector with asynchronous active-low reset.
module edge_detect_rise (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_d,
  output logic o_rise
);

  logic prev_q;
  logic prev_d;

  // Next value of the history register is simply the current input
  always_comb prev_d = i_d;

  // History register
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) prev_q <= 1'b0;
    else          prev_q <= prev_d;
  end

  // Pulse while the input is high and was low on the previous edge
  always_comb o_rise = i_d & ~prev_q;

endmodule

// File: rtl/conv_block_scheduler.sv
// Block sequencer for the column-address FSM of the 2D-convolution array.
// Walks the image in blocks of N_CONV columns with a two-column overlap.
module conv_block_scheduler
  import conv_block_scheduler_pkg::*;
#(
  parameter int unsigned NB_IMAGE  = 10,
  parameter int unsigned N_CONV    = N_CONV_DEFAULT,
  parameter int unsigned NB_STATES = 3
) (
  input  logic                    i_CLK,
  input  logic                    i_reset,
  input  logic                    i_start,
  input  logic                    i_abort,
  input  logic [NB_IMAGE-1:0]     i_imgWidth,
  input  logic [NB_IMAGE-1:0]     i_imgLength,
  input  logic                    i_changeBlock,
  input  logic                    i_EoP,
  output logic                    o_load,
  output logic                    o_SoP,
  output logic                    o_fsm_clr,
  output logic [NB_IMAGE-1:0]     o_imgLength,
  output logic [NB_IMAGE-1:0]     o_colBase,
  output logic [clog2(N_CONV):0]  o_colsInBlock,
  output logic                    o_busy,
  output logic                    o_done,
  output logic                    o_error
);

  localparam int unsigned         CW        = clog2(N_CONV) + 1;
  localparam logic [NB_IMAGE-1:0] STRIDE    = NB_IMAGE'(N_CONV - KERNEL_OVERLAP);
  localparam logic [NB_IMAGE:0]   SPAN      = (NB_IMAGE + 1)'(N_CONV);
  localparam logic [NB_IMAGE-1:0] MIN_DIM   = NB_IMAGE'(MIN_IMG_DIM);
  localparam logic [NB_IMAGE-1:0] N_CONV_IM = NB_IMAGE'(N_CONV);
  localparam logic [CW-1:0]       N_CONV_CW = CW'(N_CONV);

  typedef enum logic [NB_STATES-1:0] {
    IDLE  = NB_STATES'(ST_IDLE),
    LOAD  = NB_STATES'(ST_LOAD),
    PROC  = NB_STATES'(ST_PROC),
    DRAIN = NB_STATES'(ST_DRAIN),
    NEXT  = NB_STATES'(ST_NEXT)
  } state_t;

  state_t              state_q, state_d;
  logic                load_q, load_d;
  logic                sop_q, sop_d;
  logic                clr_q, clr_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
  logic                drain_wait_q, drain_wait_d;
  logic [NB_IMAGE-1:0] width_q, width_d;
  logic [NB_IMAGE-1:0] len_q, len_d;
  logic [NB_IMAGE-1:0] base_q, base_d;
  logic [CW-1:0]       cols_q, cols_d;
  logic [CW-1:0]       cnt_q, cnt_d;

  logic                cb_rise;
  logic                abort_rise;
  logic [NB_IMAGE:0]   end_col;
  logic [NB_IMAGE-1:0] next_base;

  // Columns in a block: a full block, or whatever remains of the image
  function automatic logic [CW-1:0] cols_for(input logic [NB_IMAGE-1:0] remaining);
    if (remaining >= N_CONV_IM) return N_CONV_CW;
    else                        return remaining[CW-1:0];
  endfunction

  edge_detect_rise u_cb_edge (
    .i_clk   (i_CLK),
    .i_rst_n (i_reset),
    .i_d     (i_changeBlock),
    .o_rise  (cb_rise)
  );

  // The FSM clear is issued once per abort assertion even if abort is held
  edge_detect_rise u_abort_edge (
    .i_clk   (i_CLK),
    .i_rst_n (i_reset),
    .i_d     (i_abort),
    .o_rise  (abort_rise)
  );

  // Block end column at one extra bit so the last-block test cannot wrap
  always_comb begin
    end_col   = {1'b0, base_q} + SPAN;
    next_base = base_q + STRIDE;
  end

  // Next-state and registered-output computation
  always_comb begin
    state_d      = state_q;
    load_d       = 1'b0;
    sop_d        = 1'b0;
    done_d       = 1'b0;
    clr_d        = abort_rise;
    err_d        = err_q;
    drain_wait_d = 1'b0;
    width_d      = width_q;
    len_d        = len_q;
    base_d       = base_q;
    cols_d       = cols_q;
    cnt_d        = cnt_q;

    if (i_abort) begin
      state_d = IDLE;
      cnt_d   = '0;
      base_d  = '0;
      cols_d  = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (i_start) begin
            if ((i_imgWidth >= MIN_DIM) && (i_imgLength >= MIN_DIM)) begin
              width_d = i_imgWidth;
              len_d   = i_imgLength;
              base_d  = '0;
              cols_d  = cols_for(i_imgWidth);
              cnt_d   = '0;
              err_d   = 1'b0;
              load_d  = 1'b1;
              state_d = LOAD;
            end else begin
              err_d = 1'b1;
            end
          end
        end
        LOAD: begin
          load_d = 1'b1;
          if (cb_rise) begin
            if (cnt_q + CW'(1) == cols_q) begin
              cnt_d   = '0;
              load_d  = 1'b0;
              sop_d   = 1'b1;
              state_d = PROC;
            end else begin
              cnt_d = cnt_q + CW'(1);
            end
          end
        end
        PROC: begin
          if (cb_rise) begin
            drain_wait_d = 1'b1;
            state_d      = DRAIN;
          end else begin
            sop_d = 1'b1;
          end
        end
        // First DRAIN cycle ignores EoP so the FSM has time to raise it
        DRAIN: begin
          if (!drain_wait_q && !i_EoP) state_d = NEXT;
        end
        NEXT: begin
          if (end_col < {1'b0, width_q}) begin
            base_d  = next_base;
            cols_d  = cols_for(width_q - next_base);
            load_d  = 1'b1;
            state_d = LOAD;
          end else begin
            done_d  = 1'b1;
            state_d = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase
    end

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge i_CLK or negedge i_reset) begin
    if (!i_reset) begin
      state_q      <= IDLE;
      load_q       <= 1'b0;
      sop_q        <= 1'b0;
      clr_q        <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      err_q        <= 1'b0;
      drain_wait_q <= 1'b0;
      width_q      <= '0;
      len_q        <= '0;
      base_q       <= '0;
      cols_q       <= '0;
      cnt_q        <= '0;
    end else begin
      state_q      <= state_d;
      load_q       <= load_d;
      sop_q        <= sop_d;
      clr_q        <= clr_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      err_q        <= err_d;
      drain_wait_q <= drain_wait_d;
      width_q      <= width_d;
      len_q        <= len_d;
      base_q       <= base_d;
      cols_q       <= cols_d;
      cnt_q        <= cnt_d;
    end
  end

  assign o_load        = load_q;
  assign o_SoP         = sop_q;
  assign o_fsm_clr     = clr_q;
  assign o_busy        = busy_q;
  assign o_done        = done_q;
  assign o_error       = err_q;
  assign o_imgLength   = len_q;
  assign o_colBase     = base_q;
  assign o_colsInBlock = cols_q;

endmodule

// File: tb/tb_conv_block_scheduler.sv
// Self-checking bench for conv_block_scheduler.
module tb_conv_block_scheduler;

  localparam int NB_IMAGE  = 10;
  localparam int N_CONV    = 16;
  localparam int NB_STATES = 3;
  localparam int STRIDE    = N_CONV - 2;
  localparam int CW        = $clog2(N_CONV) + 1;

  logic                clk = 1'b0;
  logic                rst_n = 1'b1;
  logic                i_start = 1'b0;
  logic                i_abort = 1'b0;
  logic                i_changeBlock = 1'b0;
  logic                i_EoP = 1'b0;
  logic [NB_IMAGE-1:0] i_imgWidth = '0;
  logic [NB_IMAGE-1:0] i_imgLength = '0;
  logic                o_load, o_SoP, o_fsm_clr, o_busy, o_done, o_error;
  logic [NB_IMAGE-1:0] o_imgLength, o_colBase;
  logic [CW-1:0]       o_colsInBlock;

  int checks = 0;
  int failures = 0;

  typedef struct {
    int w;
    int l;
    int eop;
    int err;
    int nblk;
    int lbase;
    int lcols;
  } vec_t;

  conv_block_scheduler #(
    .NB_IMAGE  (NB_IMAGE),
    .N_CONV    (N_CONV),
    .NB_STATES (NB_STATES)
  ) dut (
    .i_CLK         (clk),
    .i_reset       (rst_n),
    .i_start       (i_start),
    .i_abort       (i_abort),
    .i_imgWidth    (i_imgWidth),
    .i_imgLength   (i_imgLength),
    .i_changeBlock (i_changeBlock),
    .i_EoP         (i_EoP),
    .o_load        (o_load),
    .o_SoP         (o_SoP),
    .o_fsm_clr     (o_fsm_clr),
    .o_imgLength   (o_imgLength),
    .o_colBase     (o_colBase),
    .o_colsInBlock (o_colsInBlock),
    .o_busy        (o_busy),
    .o_done        (o_done),
    .o_error       (o_error)
  );

  always #5 clk = ~clk;

  // Reference model: block k starts at k*STRIDE; another block follows while base+N_CONV < width
  function automatic int exp_blocks(input int w);
    int b;
    int n;
    b = 0;
    n = 1;
    while (b + N_CONV < w) begin
      b += STRIDE;
      n++;
    end
    return n;
  endfunction

  function automatic int exp_base(input int k);
    return k * STRIDE;
  endfunction

  function automatic int exp_cols(input int w, input int k);
    int r;
    r = w - k * STRIDE;
    return (r < N_CONV) ? r : N_CONV;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Advance one clock; outputs are sampled 1 time unit after the edge
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic pulses(input int n);
    for (int i = 0; i < n; i++) begin
      i_changeBlock = 1'b1;
      step();
      i_changeBlock = 1'b0;
      step();
    end
  endtask

  // Drive one whole image as the column FSM would and check each block
  task automatic run_image(input int w, input int l, input int eop,
                           output int nblk, output int lbase, output int lcols, output int ndone);
    int  nloads;
    int  hi;
    int  lat;
    logic still;
    logic got;
    nblk  = 0;
    lbase = -1;
    lcols = -1;
    ndone = 0;
    i_imgWidth  = NB_IMAGE'(w);
    i_imgLength = NB_IMAGE'(l);
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    if (w < 3 || l < 3) begin
      chk("illegal_busy", o_busy, 0);
      return;
    end
    chk("start_err", o_error, 0);
    chk("start_busy", o_busy, 1);
    chk("start_len", o_imgLength, l);
    for (int k = 0; k < 200; k++) begin
      if (o_load !== 1'b1) begin
        chk("block_load_start", o_load, 1);
        return;
      end
      nblk++;
      lbase = int'(o_colBase);
      lcols = int'(o_colsInBlock);
      chk("blk_base", o_colBase, exp_base(k));
      chk("blk_cols", o_colsInBlock, exp_cols(w, k));
      nloads = 0;
      do begin
        hi = $urandom_range(1, 3);
        i_changeBlock = 1'b1;
        step();
        nloads++;
        still = o_load;
        repeat (hi - 1) step();
        i_changeBlock = 1'b0;
        step();
      end while (still && nloads < 40);
      chk("blk_loads", nloads, exp_cols(w, k));
      chk("sop_on", o_SoP, 1);
      i_changeBlock = 1'b1;
      step();
      chk("sop_off", o_SoP, 0);
      i_changeBlock = 1'b0;
      i_EoP = (eop != 0);
      got = 1'b0;
      lat = 0;
      for (int t = 1; t <= eop + 20 && !got; t++) begin
        step();
        if (t == eop) i_EoP = 1'b0;
        if (o_done) ndone++;
        if (o_load || o_done) begin
          got = 1'b1;
          lat = t;
        end
      end
      i_EoP = 1'b0;
      chk("drain_latency", lat, (eop + 2 > 3) ? eop + 2 : 3);
      if (!got) return;
      if (o_done) begin
        step();
        chk("done_one_cycle", o_done, 0);
        chk("idle_after_done", o_busy, 0);
        return;
      end
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs [10];
    int nb, lb, lc, nd, w, l, e;
    vecs = '{
      '{2,    16, 5, 1, 0,  0,    0},
      '{16,   10, 5, 0, 1,  0,    16},
      '{16,   2,  0, 1, 0,  0,    0},
      '{30,   10, 1, 0, 2,  14,   16},
      '{20,   10, 0, 0, 2,  14,   6},
      '{3,    3,  2, 0, 1,  0,    3},
      '{17,   5,  0, 0, 2,  14,   3},
      '{44,   8,  3, 0, 3,  28,   16},
      '{45,   8,  0, 0, 4,  42,   3},
      '{1023, 4,  1, 0, 73, 1008, 15}
    };

    #1 rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_load", o_load, 0);
    chk("rst_sop", o_SoP, 0);
    chk("rst_clr", o_fsm_clr, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_done", o_done, 0);
    chk("rst_error", o_error, 0);
    chk("rst_colbase", o_colBase, 0);
    chk("rst_cols", o_colsInBlock, 0);
    chk("rst_len", o_imgLength, 0);
    rst_n = 1'b1;
    step();

    // Table-driven images
    for (int i = 0; i < 10; i++) begin
      run_image(vecs[i].w, vecs[i].l, vecs[i].eop, nb, lb, lc, nd);
      chk("tbl_error", o_error, vecs[i].err);
      chk("tbl_nblocks", nb, vecs[i].nblk);
      chk("tbl_done_count", nd, (vecs[i].err != 0) ? 0 : 1);
      chk("tbl_idle", o_busy, 0);
      if (vecs[i].err == 0) begin
        chk("tbl_last_base", lb, vecs[i].lbase);
        chk("tbl_last_cols", lc, vecs[i].lcols);
      end
    end

    // Randomized images against the block model
    for (int i = 0; i < 12; i++) begin
      w = $urandom_range(0, 300);
      l = $urandom_range(0, 40);
      e = $urandom_range(0, 6);
      run_image(w, l, e, nb, lb, lc, nd);
      if (w < 3 || l < 3) begin
        chk("rnd_error", o_error, 1);
        chk("rnd_nblocks_illegal", nb, 0);
      end else begin
        chk("rnd_error", o_error, 0);
        chk("rnd_nblocks", nb, exp_blocks(w));
        chk("rnd_last_base", lb, exp_base(exp_blocks(w) - 1));
        chk("rnd_last_cols", lc, exp_cols(w, exp_blocks(w) - 1));
        chk("rnd_done_count", nd, 1);
      end
    end

    // Abort during PROC of the second block
    i_imgWidth = 30;
    i_imgLength = 10;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    pulses(16);
    i_changeBlock = 1'b1;
    step();
    i_changeBlock = 1'b0;
    for (int t = 0; t < 20 && !o_load; t++) step();
    chk("ab_blk2_load", o_load, 1);
    chk("ab_blk2_base", o_colBase, 14);
    pulses(16);
    chk("ab_in_proc", o_SoP, 1);
    i_abort = 1'b1;
    step();
    chk("ab_busy", o_busy, 0);
    chk("ab_clr", o_fsm_clr, 1);
    chk("ab_sop", o_SoP, 0);
    chk("ab_load", o_load, 0);
    chk("ab_done", o_done, 0);
    step();
    chk("ab_clr_one_cycle", o_fsm_clr, 0);
    i_abort = 1'b0;
    step();
    chk("ab_no_done", o_done, 0);
    chk("ab_still_idle", o_busy, 0);

    // Illegal start, then abort coincident with a legal start
    i_imgWidth = 2;
    i_imgLength = 10;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("ill_error", o_error, 1);
    chk("ill_busy", o_busy, 0);
    i_imgWidth = 16;
    i_start = 1'b1;
    i_abort = 1'b1;
    step();
    i_start = 1'b0;
    i_abort = 1'b0;
    chk("abst_busy", o_busy, 0);
    chk("abst_clr", o_fsm_clr, 1);
    chk("abst_error_kept", o_error, 1);
    step();
    chk("abst_idle", o_busy, 0);
    chk("abst_clr_off", o_fsm_clr, 0);

    // Change-block events in IDLE are ignored
    pulses(2);
    chk("idle_cb_busy", o_busy, 0);
    chk("idle_cb_load", o_load, 0);

    // Held change-block counts once
    i_imgWidth = 3;
    i_imgLength = 3;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    chk("held_start_cols", o_colsInBlock, 3);
    i_changeBlock = 1'b1;
    repeat (4) step();
    i_changeBlock = 1'b0;
    step();
    chk("held_one_event", o_load, 1);
    pulses(1);
    chk("held_two_events", o_load, 1);
    i_changeBlock = 1'b1;
    step();
    chk("held_third_event", o_load, 0);
    i_changeBlock = 1'b0;
    i_abort = 1'b1;
    step();
    i_abort = 1'b0;
    step();

    // Asynchronous reset mid-LOAD
    i_imgWidth = 16;
    i_imgLength = 10;
    i_start = 1'b1;
    step();
    i_start = 1'b0;
    pulses(3);
    chk("ar_in_load", o_load, 1);
    #3 rst_n = 1'b0;
    #1;
    chk("ar_load", o_load, 0);
    chk("ar_busy", o_busy, 0);
    chk("ar_cols", o_colsInBlock, 0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    step();
    chk("ar_no_done", o_done, 0);
    chk("ar_idle", o_busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
